// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel word deserialiser.
package deser_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Counter must hold WIDTH+1 frame positions when the parity bit is enabled.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

endpackage

// File: rtl/deser_if.sv
// Serial input / parallel ready-valid output bundle of deser_word.
interface deser_if
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
);

  logic             bit_in;
  logic             bit_valid;
  logic             msb_first;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
  logic             parity_err;

  modport master (
    output bit_in, bit_valid, msb_first, flush, out_ready,
    input  out_word, out_valid, bit_count, overrun, parity_err
  );

  modport slave (
    input  bit_in, bit_valid, msb_first, flush, out_ready,
    output out_word, out_valid, bit_count, overrun, parity_err
  );

endinterface

// File: rtl/deser_out_reg.sv
// Ready/valid holding register for completed words, with sticky overrun flag.
module deser_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             load_perr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;
  logic             accept;

  always_comb begin
    accept  = load && (!valid_q || out_ready);
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
    if (flush) begin
      word_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      perr_d  = 1'b0;
    end else begin
      if (accept) begin
        word_d  = load_word;
        perr_d  = load_perr;
        valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      // A completed frame that cannot be accepted is dropped.
      if (load && !accept) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign out_word   = word_q;
  assign out_valid  = valid_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

// File: rtl/deser_word.sv
// Serial-to-parallel deserialiser with selectable bit order.
// Define DESER_PARITY_EN to append and check an even-parity bit per frame.
module deser_word
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input logic    clk,
  input logic    rst,
  deser_if.slave bus
);

`ifdef DESER_PARITY_EN
  localparam int unsigned Flen = WIDTH + 1;
`else
  localparam int unsigned Flen = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Flen - 1);

  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0] count_q, count_d;
  bit_order_e       order_q, order_d, order_cur;
  logic             last_bit;
  logic             frame_done;
  logic [WIDTH-1:0] done_word;
  logic             done_perr;

  always_comb begin
    // Order is taken live on the first bit of a frame, then held.
    if (count_q == '0) begin
      order_cur = bus.msb_first ? MSB_FIRST : LSB_FIRST;
    end else begin
      order_cur = order_q;
    end
    if (order_cur == MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], bus.bit_in};
    end else begin
      shifted = {bus.bit_in, shift_q[WIDTH-1:1]};
    end
    last_bit   = (count_q == LastCnt);
    frame_done = bus.bit_valid && !bus.flush && last_bit;
  end

`ifdef DESER_PARITY_EN
  // Final bit is parity: the data is already complete in the shift register.
  assign done_word = shift_q;
  assign done_perr = (^shift_q) ^ bus.bit_in;
`else
  assign done_word = shifted;
  assign done_perr = 1'b0;
`endif

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    order_d = order_q;
    if (bus.flush) begin
      shift_d = '0;
      count_d = '0;
    end else if (bus.bit_valid) begin
      order_d = order_cur;
      if (last_bit) begin
        shift_d = '0;
        count_d = '0;
      end else begin
        shift_d = shifted;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
      order_q <= MSB_FIRST;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      order_q <= order_d;
    end
  end

  deser_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .load       (frame_done),
    .load_word  (done_word),
    .load_perr  (done_perr),
    .out_ready  (bus.out_ready),
    .out_word   (bus.out_word),
    .out_valid  (bus.out_valid),
    .overrun    (bus.overrun),
    .parity_err (bus.parity_err)
  );

  assign bus.bit_count = count_q;

endmodule

// File: tb/tb_deser_word.sv
// Directed self-checking bench for deser_word (WIDTH=8).
module tb_deser_word;

`ifdef DESER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  deser_if #(.WIDTH(8), .CNT_W(4)) bus ();

  deser_word #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drive one valid bit at the next negedge; returns 1 time unit after the sampling edge.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic msb);
    for (int i = 0; i < 8; i++) drive_bit(msb ? w[7-i] : w[i]);
`ifdef DESER_PARITY_EN
    drive_bit(^w);
`endif
  endtask

  task automatic test_reset;
    n_total++;
    if (bus.out_word !== 8'h00) $display("FAIL reset_word: got %h want 00", bus.out_word);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.bit_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.bit_count);
    else n_pass++;
    n_total++;
    if ({bus.overrun, bus.parity_err} !== 2'b00)
      $display("FAIL reset_flags: got %b want 00", {bus.overrun, bus.parity_err});
    else n_pass++;
  endtask

  task automatic test_msb_first;
    logic [7:0] w = 8'hAA;
    bus.out_ready = 1'b1;
    bus.msb_first = 1'b1;
    for (int i = 0; i < 7; i++) drive_bit(w[7-i]);
    n_total++;
    if (bus.bit_count !== 4'd7 || bus.out_valid !== 1'b0)
      $display("FAIL msb_pre: got count %0d valid %b want 7 0", bus.bit_count, bus.out_valid);
    else n_pass++;
    drive_bit(w[0]);
`ifdef DESER_PARITY_EN
    drive_bit(1'b0);
`endif
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 8'hAA || bus.bit_count !== 4'd0)
      $display("FAIL msb_word: got valid %b word %h count %0d want 1 aa 0",
               bus.out_valid, bus.out_word, bus.bit_count);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL msb_pulse: got valid %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_lsb_first;
    logic [7:0] w = 8'hAA;
    bus.msb_first = 1'b0;
    drive_bit(w[7]);
    bus.msb_first = 1'b1;  // mid-frame change must be ignored
    for (int i = 1; i < 8; i++) drive_bit(w[7-i]);
`ifdef DESER_PARITY_EN
    drive_bit(1'b0);
`endif
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 8'h55)
      $display("FAIL lsb_word: got valid %b word %h want 1 55", bus.out_valid, bus.out_word);
    else n_pass++;
  endtask

  task automatic test_gaps;
    logic [8:0] bits = 9'b1111_0000_0;
    int         exp_cnt = 0;
    bus.msb_first = 1'b1;
    for (int i = 0; i < FLEN; i++) begin
      drive_bit(bits[8-i]);
      exp_cnt = (i + 1) % FLEN;
      n_total++;
      if (bus.bit_count !== 4'(exp_cnt))
        $display("FAIL gap_valid_cnt[%0d]: got %0d want %0d", i, bus.bit_count, exp_cnt);
      else n_pass++;
      @(negedge clk);
      bus.bit_in = ~bus.bit_in;  // junk with bit_valid low
      @(posedge clk);
      #1;
      n_total++;
      if (bus.bit_count !== 4'(exp_cnt))
        $display("FAIL gap_idle_cnt[%0d]: got %0d want %0d", i, bus.bit_count, exp_cnt);
      else n_pass++;
    end
    n_total++;
    if (bus.out_word !== 8'hF0) $display("FAIL gap_word: got %h want f0", bus.out_word);
    else n_pass++;
  endtask

  task automatic test_overrun;
    bus.out_ready = 1'b0;
    bus.msb_first = 1'b1;
    send_word(8'hA5, 1'b1);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 8'hA5 || bus.overrun !== 1'b0)
      $display("FAIL ovr_first: got valid %b word %h ovr %b want 1 a5 0",
               bus.out_valid, bus.out_word, bus.overrun);
    else n_pass++;
    send_word(8'h3C, 1'b1);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 8'hA5 || bus.overrun !== 1'b1)
      $display("FAIL ovr_drop: got valid %b word %h ovr %b want 1 a5 1",
               bus.out_valid, bus.out_word, bus.overrun);
    else n_pass++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1)
      $display("FAIL ovr_consume: got valid %b ovr %b want 0 1", bus.out_valid, bus.overrun);
    else n_pass++;
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    n_total++;
    if (bus.overrun !== 1'b0 || bus.out_word !== 8'h00)
      $display("FAIL ovr_flush: got ovr %b word %h want 0 00", bus.overrun, bus.out_word);
    else n_pass++;
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    n_total++;
    if (bus.bit_count !== 4'd5) $display("FAIL flush_pre: got %0d want 5", bus.bit_count);
    else n_pass++;
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.bit_valid = 1'b1;  // flush outranks a valid bit
    bus.bit_in    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.bit_valid = 1'b0;
    n_total++;
    if (bus.bit_count !== 4'd0) $display("FAIL flush_cnt: got %0d want 0", bus.bit_count);
    else n_pass++;
    send_word(8'h0F, 1'b1);
    n_total++;
    if (bus.out_word !== 8'h0F || bus.out_valid !== 1'b1)
      $display("FAIL flush_word: got %h valid %b want 0f 1", bus.out_word, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    bus.out_ready = 1'b0;
    send_word(8'h3C, 1'b1);  // previous 0F still held -> overrun
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    n_total++;
    if (bus.bit_count !== 4'd3 || bus.overrun !== 1'b1 || bus.out_word !== 8'h0F)
      $display("FAIL arst_pre: got cnt %0d ovr %b word %h want 3 1 0f",
               bus.bit_count, bus.overrun, bus.out_word);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.out_word !== 8'h00 || bus.out_valid !== 1'b0 || bus.bit_count !== 4'd0 ||
        bus.overrun !== 1'b0 || bus.parity_err !== 1'b0)
      $display("FAIL arst_clear: got word %h valid %b cnt %0d ovr %b perr %b want all 0",
               bus.out_word, bus.out_valid, bus.bit_count, bus.overrun, bus.parity_err);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_word(8'hC3, 1'b1);
    n_total++;
    if (bus.out_word !== 8'hC3 || bus.out_valid !== 1'b1)
      $display("FAIL arst_new: got %h valid %b want c3 1", bus.out_word, bus.out_valid);
    else n_pass++;
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity;
    logic [7:0] w = 8'hA5;
    bus.out_ready = 1'b1;
    bus.msb_first = 1'b1;
    for (int i = 0; i < 8; i++) drive_bit(w[7-i]);
    drive_bit(1'b1);
    n_total++;
    if (bus.parity_err !== 1'b1 || bus.out_word !== 8'hA5)
      $display("FAIL par_bad: got perr %b word %h want 1 a5", bus.parity_err, bus.out_word);
    else n_pass++;
    for (int i = 0; i < 8; i++) drive_bit(w[7-i]);
    drive_bit(1'b0);
    n_total++;
    if (bus.parity_err !== 1'b0 || bus.out_word !== 8'hA5)
      $display("FAIL par_good: got perr %b word %h want 0 a5", bus.parity_err, bus.out_word);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.msb_first = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_msb_first();
    test_lsb_first();
    test_gaps();
    test_overrun();
    test_flush();
    test_async_reset();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/deser_word.md
DESER_WORD -- requirements
Module: deser_word

Interface
REQ-001 Parameter WIDTH, default 8, data bits per word; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+2), width of bit_count.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 bit_in  input  1  serial data bit.
REQ-007 bit_valid  input  1  bit_in is sampled on this edge.
REQ-008 msb_first  input  1  bit order: 1 = first bit received lands in out_word[WIDTH-1]; 0 = first bit lands in out_word[0].
REQ-009 flush  input  1  synchronous clear.
REQ-010 out_ready  input  1  consumer accepts out_word.
REQ-011 out_word  output  WIDTH  assembled word, registered.
REQ-012 out_valid  output  1  out_word holds an unconsumed word.
REQ-013 bit_count  output  CNT_W  bits collected for the current frame.
REQ-014 overrun  output  1  sticky: a completed word was dropped.
REQ-015 parity_err  output  1  parity flag of the word in out_word.

Function
REQ-016 A bit is shifted in only on a rising edge with bit_valid=1 and flush=0; bit_in is ignored when bit_valid=0.
REQ-017 msb_first is latched when bit_count=0 and a valid bit arrives; changes mid-frame have no effect until the next frame.
REQ-018 MSB-first shifts left, with the new bit entering at bit 0; LSB-first shifts right, with the new bit entering at bit WIDTH-1.
REQ-019 Frame length is FLEN = WIDTH bits, or WIDTH+1 bits with parity (REQ-031).
REQ-020 bit_count increments per valid bit and returns to 0 on the edge that samples the last bit of the frame.
REQ-021 On that edge, the completed word, including the last bit, is loaded into out_word when out_valid=0 or out_ready=1. out_valid is 1 in the following cycle, so latency is one cycle.
REQ-022 An edge with out_valid=1 and out_ready=1 consumes the word; out_valid drops to 0 unless a new word loads on the same edge, in which case it stays 1.
REQ-023 out_word and out_valid remain stable while out_valid=1 and out_ready=0.
REQ-024 Overrun: a frame that completes while out_valid=1 and out_ready=0 is discarded; overrun goes to 1 and remains 1 until flush or rst.
REQ-025 flush takes priority over bit_valid and out_ready; it clears the shift register, bit_count, out_word, out_valid, overrun and parity_err on the same edge.

Reset
REQ-026 rst=1 immediately forces, without waiting for a clock edge: out_word=0, out_valid=0, bit_count=0, overrun=0, parity_err=0, shift register=0 and latched order=MSB-first.
REQ-027 Reset mid-frame discards the partial word; the first valid bit after release starts a new frame.
REQ-028 Release of rst is synchronous to clk by the system; the block adds no synchroniser.

Configuration
REQ-029 Macro DESER_PARITY_EN selects parity checking.
REQ-030 Without DESER_PARITY_EN: FLEN=WIDTH and parity_err is tied to 0.
REQ-031 With DESER_PARITY_EN:
  - FLEN=WIDTH+1; the final bit is an even-parity bit over the WIDTH data bits.
  - The parity bit is not stored in out_word.
  - parity_err is loaded with out_word and equals 1 when XOR(data bits, parity bit)=1.
  - Words with bad parity are still delivered.

Structure
REQ-032 Package deser_pkg holds the default WIDTH, the count-width function, and a bit_order_e typedef (MSB_FIRST, LSB_FIRST).
REQ-033 Sub-module deser_out_reg implements the ready/valid holding register and overrun logic; deser_word instantiates it once.

Verification
REQ-034 WIDTH=8, msb_first=1, out_ready=1; bits 1,0,1,0,1,0,1,0 on consecutive edges -> out_word=8'hAA with a one-cycle out_valid pulse, one cycle after the 8th edge.
REQ-035 Same bits with msb_first=0 -> out_word=8'h55.
REQ-036 Bits 1,1,1,1,0,0,0,0 with bit_valid low on alternate cycles -> bit_count advances only on valid edges; out_word=8'hF0.
REQ-037 out_ready=0; frames 8'hA5 then 8'h3C ->
  - out_word stays 8'hA5 and overrun=1;
  - then out_ready=1 for one edge -> out_valid=0 and overrun stays 1;
  - then flush -> overrun=0.
REQ-038 Five bits, then flush, then frame 8'h0F -> bit_count=0 after flush and out_word=8'h0F.
REQ-039 rst asserted between edges after 3 bits -> all outputs 0 without a clock edge.
  - With DESER_PARITY_EN: frame 8'hA5 followed by parity bit 1 -> parity_err=1.
  - With DESER_PARITY_EN: frame 8'hA5 followed by parity bit 0 -> parity_err=0.
